// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } arb_state_t;

  function automatic logic isBusy(arb_state_t s);
    return s != IDLE;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/ack bus between the arbiter (master) and the single-port memory (slave).
interface mem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);

endinterface

// File: rtl/flopenr.sv
// Enabled flop with synchronous active-high reset.
module flopenr #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch (I) and memory-stage (D) accesses onto one single-port memory,
// with stall generation and a watchdog that aborts accesses whose ack never arrives.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ifreq,
  input  logic [AW-1:0] ifaddr,
  output logic [DW-1:0] ifrdata,
  output logic          ifdone,
  input  logic          dreq,
  input  logic          dwe,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dwdata,
  output logic [DW-1:0] drdata,
  output logic          ddone,
  mem_arbiter_if.master mem,
  output logic          stallF,
  output logic          stallM,
  output logic          err
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  arb_state_t    state;
  arb_state_t    stateNext;
  logic [CW-1:0] wdCount;
  logic          busy;
  logic          abort;
  logic          accDone;
  logic          capI;
  logic          capD;
  logic          reqQ;
  logic          errQ;

  // An access finishes on ack or when the watchdog expires.
  assign busy    = isBusy(state);
  assign abort   = busy && !mem.ack && (wdCount == CW'(TIMEOUT - 1));
  assign accDone = busy && (mem.ack || abort);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // D wins from IDLE; on completion the other port is served next so neither starves.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (dreq)       stateNext = DBUSY;
        else if (ifreq) stateNext = IBUSY;
      end
      IBUSY: if (accDone) stateNext = dreq  ? DBUSY : IDLE;
      DBUSY: if (accDone) stateNext = ifreq ? IBUSY : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    ifdone  = 1'b0;
    ddone   = 1'b0;
    ifrdata = '0;
    drdata  = '0;
    capI    = (stateNext == IBUSY) && (state != IBUSY);
    capD    = (stateNext == DBUSY) && (state != DBUSY);
    if (!reset && accDone) begin
      if (state == IBUSY) begin
        ifdone  = 1'b1;
        ifrdata = mem.ack ? mem.rdata : '0;
      end else begin
        ddone  = 1'b1;
        drdata = mem.ack ? mem.rdata : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) reqQ <= 1'b0;
    else       reqQ <= isBusy(stateNext);
  end

  flopenr #(.WIDTH(AW)) addrReg (
    .clk(clk), .reset(reset), .en(capI || capD),
    .d(capD ? daddr : ifaddr), .q(mem.addr)
  );

  flopenr #(.WIDTH(1)) weReg (
    .clk(clk), .reset(reset), .en(capI || capD),
    .d(capD && dwe), .q(mem.we)
  );

  flopenr #(.WIDTH(DW)) wdataReg (
    .clk(clk), .reset(reset), .en(capD),
    .d(dwdata), .q(mem.wdata)
  );

  // Count restarts whenever a new access begins (from IDLE or back-to-back).
  always_ff @(posedge clk) begin
    if (reset)                 wdCount <= '0;
    else if (!busy || accDone) wdCount <= '0;
    else                       wdCount <= wdCount + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)      errQ <= 1'b0;
    else if (abort) errQ <= 1'b1;
  end

  assign mem.req = reqQ;
  assign err     = errQ;
  assign stallF  = ifreq & ~ifdone;
  assign stallM  = dreq & ~ddone;

endmodule
